// File: rtl/normalize_pkg.sv
// Shared definitions for the sequential leading-zero normalizer: FSM states
// and the nibble-scan constants used with the 4-bit lzd.
package normalize_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } stateT;

    localparam int NIBBLE = 4;

    // lzd reports this code when the whole nibble is zero
    localparam logic [2:0] LZD_ALLZERO = 3'd4;

endpackage

// File: rtl/lzd.sv
// 4-bit leading-zero detector: returns 0..3 for a nonzero nibble, 4 when all zero.
module lzd (
    input  logic [3:0] lzdIn,
    output logic [2:0] lzdOut
);

    always_comb begin
        lzdOut = 3'd4;
        casez (lzdIn)
            4'b1???: lzdOut = 3'd0;
            4'b01??: lzdOut = 3'd1;
            4'b001?: lzdOut = 3'd2;
            4'b0001: lzdOut = 3'd3;
            default: lzdOut = 3'd4;
        endcase
    end

endmodule

// File: rtl/normalize16.sv
// Sequential normalizer: scans the captured word one nibble per cycle through
// a single lzd, then barrel-shifts it left so the MSB is set.
module normalize16
    import normalize_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LZW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic [LZW-1:0]   lzc,
    output logic [WIDTH-1:0] mant
);

    localparam int NIBBLES = WIDTH / NIBBLE;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NIBBLES - 1);

    stateT              stateReg;
    logic [WIDTH-1:0]   dataReg;
    logic [IDXW-1:0]    idxReg;
    logic [LZW-1:0]     accReg;
    logic               zeroFlagReg;
    logic [LZW-1:0]     lzcReg;
    logic               zeroReg;
    logic [WIDTH-1:0]   mantReg;

    logic [3:0]         lzdIn;
    logic [2:0]         lzdOut;
    logic [LZW-1:0]     accSum;

    assign lzdIn  = dataReg[idxReg*NIBBLE +: NIBBLE];
    assign accSum = accReg + LZW'(lzdOut);

    lzd uLzd (
        .lzdIn  (lzdIn),
        .lzdOut (lzdOut)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= IDLE;
            dataReg     <= '0;
            idxReg      <= TOP_IDX;
            accReg      <= '0;
            zeroFlagReg <= 1'b0;
            lzcReg      <= '0;
            zeroReg     <= 1'b0;
            mantReg     <= '0;
        end else begin
            case (stateReg)
                IDLE, DONE: begin
                    // DONE accepts too, so requests can run back to back
                    if (start) begin
                        dataReg     <= din;
                        accReg      <= '0;
                        idxReg      <= TOP_IDX;
                        zeroFlagReg <= 1'b0;
                        stateReg    <= SCAN;
                    end else begin
                        stateReg    <= IDLE;
                    end
                end
                SCAN: begin
                    accReg <= accSum;
                    if (lzdOut == LZD_ALLZERO) begin
                        if (idxReg == '0) begin
                            zeroFlagReg <= 1'b1;
                            stateReg    <= SHIFT;
                        end else begin
                            idxReg <= idxReg - IDXW'(1);
                        end
                    end else begin
                        stateReg <= SHIFT;
                    end
                end
                SHIFT: begin
                    // a shift by WIDTH naturally yields zero
                    mantReg  <= dataReg << accReg;
                    lzcReg   <= accReg;
                    zeroReg  <= zeroFlagReg;
                    stateReg <= DONE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign busy = (stateReg == SCAN) || (stateReg == SHIFT);
    assign done = (stateReg == DONE);
    assign zero = zeroReg;
    assign lzc  = lzcReg;
    assign mant = mantReg;

endmodule

// File: tb/tb_normalize16.sv
// Directed bench for normalize16: hand-computed latency, count, flag and
// normalized-word checks, including ignored starts, back-to-back and reset abort.
module tb_normalize16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic        zero;
    logic [4:0]  lzc;
    logic [15:0] mant;

    int vecCount;
    int missCount;

    normalize16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .lzc   (lzc),
        .mant  (mant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; the edge that ends this call's first cycle accepts.
    task automatic runOp(input logic [15:0] d, input int expLat, input int expLzc,
                         input logic [15:0] expMant, input logic expZero, input bit noise);
        int lat;
        bit seen;
        start = 1'b1;
        din   = d;
        @(posedge clk); #1;
        start = 1'b0;
        din   = 16'h5A5A;
        lat   = 1;
        seen  = 1'b0;
        checkVal($sformatf("busy_after_accept_%h", d), {31'b0, busy}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (noise) begin
                start = 1'b1;
                din   = 16'hFFFF ^ 16'(i);
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        checkVal($sformatf("done_seen_%h", d), {31'b0, seen}, 32'd1);
        checkVal($sformatf("latency_%h", d), 32'(lat), 32'(expLat));
        checkVal($sformatf("lzc_%h", d), {27'b0, lzc}, 32'(expLzc));
        checkVal($sformatf("mant_%h", d), {16'b0, mant}, {16'b0, expMant});
        checkVal($sformatf("zero_%h", d), {31'b0, zero}, {31'b0, expZero});
        checkVal($sformatf("busy_in_done_%h", d), {31'b0, busy}, 32'd0);
        $display("op din=%h lat=%0d lzc=%0d mant=%h zero=%0b", d, lat, lzc, mant, zero);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checkVal(tag, {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        reset = 1'b1;
        start = 1'b0;
        din   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkVal("rst_busy", {31'b0, busy}, 32'd0);
        checkVal("rst_done", {31'b0, done}, 32'd0);
        checkVal("rst_zero", {31'b0, zero}, 32'd0);
        checkVal("rst_lzc",  {27'b0, lzc},  32'd0);
        checkVal("rst_mant", {16'b0, mant}, 32'd0);
        din = 16'hFFFF;
        idleCycles(4, "idle_no_done");

        runOp(16'h8000, 3, 0, 16'h8000, 1'b0, 1'b0);
        idleCycles(1, "done_one_cycle");

        // back-to-back: second start is presented in the DONE cycle
        runOp(16'h00A3, 5, 8, 16'hA300, 1'b0, 1'b0);
        runOp(16'h0F00, 4, 4, 16'hF000, 1'b0, 1'b0);
        idleCycles(2, "idle_after_b2b");

        runOp(16'h0001, 6, 15, 16'h8000, 1'b0, 1'b0);
        idleCycles(1, "idle_gap");
        runOp(16'h0000, 6, 16, 16'h0000, 1'b1, 1'b0);
        runOp(16'h0050, 5, 9, 16'hA000, 1'b0, 1'b0);
        idleCycles(1, "idle_gap2");

        // starts with other data while busy must be ignored
        runOp(16'h1234, 3, 3, 16'h91A0, 1'b0, 1'b1);
        runOp(16'h0003, 6, 14, 16'hC000, 1'b0, 1'b1);
        idleCycles(1, "idle_after_noise");

        // reset during SCAN of 16'h0001
        start = 1'b1;
        din   = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checkVal("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkVal("abort_busy", {31'b0, busy}, 32'd0);
        checkVal("abort_done", {31'b0, done}, 32'd0);
        checkVal("abort_zero", {31'b0, zero}, 32'd0);
        checkVal("abort_lzc",  {27'b0, lzc},  32'd0);
        checkVal("abort_mant", {16'b0, mant}, 32'd0);
        idleCycles(8, "abort_no_done");

        runOp(16'h0200, 4, 6, 16'h8000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
